// File: rtl/status_reg.sv
`default_nettype none
// ============================================================================
// Module   : status_reg
// Purpose  : 6502 processor status register (P). It sits directly after the
//            ALU and captures the ALU flags {N,V,Z,C} under a
//            per-instruction update mask. It also executes the flag-only
//            instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), BIT, PLP/RTI and
//            interrupt/BRK entry. Carry is fed back to the ALU, the
//            interrupt logic gets an instruction-delayed copy of I, and the
//            byte pushed by PHP/BRK/IRQ/NMI is generated here.
//
// Config   : `define STATUS_REG_DECIMAL_EN to make D a real storage bit.
//            When it is not defined (2A03 style), D always reads 0, and
//            writes to D from sc_en or plp_load are ignored.
//
// Parameters
//   RESET_P      P value loaded by reset (default 8'h24: I=1, bit5=1)
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active high
//   alu_flags    in   4  ALU flags {N,V,Z,C}
//   flag_we      in   1  load flags selected by upd_mask
//   upd_mask     in   4  {N,V,Z,C} per-flag write enable (qualified by flag_we)
//   bit_op       in   1  BIT: N,V come from mem_data[7:6]
//   mem_data     in   8  data-bus operand byte (BIT)
//   sc_en        in   1  set/clear a single flag
//   sc_sel       in   2  00=C 01=I 10=D 11=V
//   sc_val       in   1  value written by sc_en
//   plp_load     in   1  load P from p_in (PLP/RTI)
//   p_in         in   8  byte pulled from the stack
//   irq_entry    in   1  interrupt/BRK entry, forces I=1
//   instr_done   in   1  last cycle of the current instruction
//   push_b       in   1  B bit for push_byte (1 = PHP/BRK, 0 = IRQ/NMI)
//   p_out        out  8  current P {N,V,1,0,D,I,Z,C}
//   push_byte    out  8  p_out with bit4 = push_b and bit5 = 1
//   carry_out    out  1  P.C, to the ALU carry input
//   decimal      out  1  P.D
//   irq_mask     out  1  I as seen by the interrupt logic (delayed)
//
// Revision : 1.0  initial release
// ============================================================================
module status_reg #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] alu_flags,
    input  logic       flag_we,
    input  logic [3:0] upd_mask,
    input  logic       bit_op,
    input  logic [7:0] mem_data,
    input  logic       sc_en,
    input  logic [1:0] sc_sel,
    input  logic       sc_val,
    input  logic       plp_load,
    input  logic [7:0] p_in,
    input  logic       irq_entry,
    input  logic       instr_done,
    input  logic       push_b,
    output logic [7:0] p_out,
    output logic [7:0] push_byte,
    output logic       carry_out,
    output logic       decimal,
    output logic       irq_mask
);

    // ------------------------------------------------------------------
    // Encodings and bit positions
    // ------------------------------------------------------------------
    localparam logic [1:0] SEL_C = 2'b00;
    localparam logic [1:0] SEL_I = 2'b01;
    localparam logic [1:0] SEL_D = 2'b10;
    localparam logic [1:0] SEL_V = 2'b11;

    localparam int unsigned BIT_N = 7;
    localparam int unsigned BIT_V = 6;
    localparam int unsigned BIT_D = 3;
    localparam int unsigned BIT_I = 2;
    localparam int unsigned BIT_Z = 1;
    localparam int unsigned BIT_C = 0;

    localparam int unsigned MSK_N = 3;
    localparam int unsigned MSK_V = 2;
    localparam int unsigned MSK_Z = 1;
    localparam int unsigned MSK_C = 0;

    // ------------------------------------------------------------------
    // Flag storage. Bits 5 and 4 are not stored; they are constants on
    // read (1 and 0) and are only substituted on the pushed byte.
    // ------------------------------------------------------------------
    logic n_q, n_d;
    logic v_q, v_d;
    logic i_q, i_d;
    logic z_q, z_d;
    logic c_q, c_d;
    logic d_q;
    logic irq_mask_q, irq_mask_d;

    // Source for N and V under flag_we. BIT takes bits 7:6 of the operand.
    // Z and C always come from the ALU.
    logic src_n;
    logic src_v;

    assign src_n = bit_op ? mem_data[7] : alu_flags[3];
    assign src_v = bit_op ? mem_data[6] : alu_flags[2];

    // ------------------------------------------------------------------
    // Next-state for the stored flags. Writers are applied from lowest
    // to highest priority, so a later assignment overrides an earlier one
    // only for the flag that it actually writes. This gives the bitwise
    // merge of sc_en with flag_we.
    // ------------------------------------------------------------------
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;

        if (flag_we) begin
            if (upd_mask[MSK_N]) n_d = src_n;
            if (upd_mask[MSK_V]) v_d = src_v;
            if (upd_mask[MSK_Z]) z_d = alu_flags[1];
            if (upd_mask[MSK_C]) c_d = alu_flags[0];
        end

        if (sc_en) begin
            case (sc_sel)
                SEL_C:   c_d = sc_val;
                SEL_I:   i_d = sc_val;
                SEL_V:   v_d = sc_val;
                default: ;  // SEL_D is handled with the D storage below
            endcase
        end

        if (plp_load) begin
            n_d = p_in[BIT_N];
            v_d = p_in[BIT_V];
            i_d = p_in[BIT_I];
            z_d = p_in[BIT_Z];
            c_d = p_in[BIT_C];
        end

        // Interrupt entry masks further IRQs regardless of other writers.
        if (irq_entry) begin
            i_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Delayed interrupt mask. It samples the I value after this cycle's
    // update at each instruction boundary. A CLI/SEI/PLP mid-instruction
    // therefore reaches the interrupt logic only at the next boundary.
    // Interrupt entry closes the mask on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (instr_done) begin
            irq_mask_d = i_d;
        end
        if (irq_entry) begin
            irq_mask_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= RESET_P[BIT_N];
            v_q        <= RESET_P[BIT_V];
            i_q        <= RESET_P[BIT_I];
            z_q        <= RESET_P[BIT_Z];
            c_q        <= RESET_P[BIT_C];
            irq_mask_q <= 1'b1;
        end else begin
            n_q        <= n_d;
            v_q        <= v_d;
            i_q        <= i_d;
            z_q        <= z_d;
            c_q        <= c_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Decimal flag (optional storage)
    // ------------------------------------------------------------------
`ifdef STATUS_REG_DECIMAL_EN
    logic d_d;

    always_comb begin
        d_d = d_q;
        if (sc_en && (sc_sel == SEL_D)) begin
            d_d = sc_val;
        end
        if (plp_load) begin
            d_d = p_in[BIT_D];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= RESET_P[BIT_D];
        end else begin
            d_q <= d_d;
        end
    end

    // Stack bits 5/4 have no storage, so they are deliberately dropped.
    logic w_unused_pin;
    assign w_unused_pin = ^p_in[5:4];
`else
    // 2A03 style: D is hard-wired to 0. Stack bits 5..3 are discarded.
    assign d_q = 1'b0;

    logic w_unused_pin;
    assign w_unused_pin = ^p_in[5:3];
`endif

    // ------------------------------------------------------------------
    // Outputs: plain decodes of the stored state
    // ------------------------------------------------------------------
    assign p_out     = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
    assign push_byte = {n_q, v_q, 1'b1, push_b, d_q, i_q, z_q, c_q};
    assign carry_out = c_q;
    assign decimal   = d_q;
    assign irq_mask  = irq_mask_q;

endmodule
`default_nettype wire
